// File: rtl/neuron_pkg.sv
// rtl/neuron_pkg.sv - shared types and helpers for the serial neuron pipe
package neuron_pkg;

  typedef enum logic [1:0] {
    MODE_LIN     = 2'b00,
    MODE_CUBIC   = 2'b01,
    MODE_RELU    = 2'b10,
    MODE_LIN_ALT = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACC,
    ST_SCALE,
    ST_ACT1,
    ST_ACT2,
    ST_OUT
  } state_e;

  // Clip a signed value into the two's complement range of `width` bits.
  function automatic logic signed [31:0] sat_to(input logic signed [31:0] v, input int width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

  function automatic int one_val(input int frac);
    return 1 << frac;
  endfunction

endpackage

// File: rtl/serial_neuron_pipe_if.sv
// rtl/serial_neuron_pipe_if.sv - operand stream and result handshake bundle
interface serial_neuron_pipe_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_x;
  logic [WIDTH-1:0] in_w;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic             out_ovf;

  modport master (
    output in_valid, in_x, in_w, out_ready,
    input  in_ready, out_valid, out_y, out_ovf
  );

  modport slave (
    input  in_valid, in_x, in_w, out_ready,
    output in_ready, out_valid, out_y, out_ovf
  );
endinterface

// File: rtl/neuron_act.sv
// rtl/neuron_act.sv - two-stage activation datapath (cubic path under NEURON_CUBIC_ACT_EN)
module neuron_act
  import neuron_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int FRAC  = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    act1_en,
  input  logic                    act2_en,
  input  logic signed [WIDTH-1:0] x,
  input  mode_e                   mode,
  output logic signed [WIDTH-1:0] y
);

  logic signed [WIDTH-1:0] x1_q, x1_d;
  logic signed [WIDTH-1:0] y_q, y_d;

`ifdef NEURON_CUBIC_ACT_EN
  localparam int W3  = 3 * WIDTH;
  localparam int ONE = one_val(FRAC);

  logic signed [2*WIDTH-1:0] x2_q, x2_d;
  logic signed [2*WIDTH-1:0] sq;
  logic signed [W3-1:0]      x1_ext;
  logic signed [W3-1:0]      cube;
  logic signed [W3-1:0]      x3;
  logic signed [W3-1:0]      y_cubic;
  logic signed [31:0]        y_sat;
`endif

  always_comb begin
    x1_d = act1_en ? x : x1_q;
`ifdef NEURON_CUBIC_ACT_EN
    sq      = {{WIDTH{x[WIDTH-1]}}, x} * {{WIDTH{x[WIDTH-1]}}, x};
    x2_d    = act1_en ? (sq >>> FRAC) : x2_q;
    x1_ext  = {{(2*WIDTH){x1_q[WIDTH-1]}}, x1_q};
    cube    = {{WIDTH{x2_q[2*WIDTH-1]}}, x2_q} * x1_ext;
    x3      = cube >>> FRAC;
    // Odd polynomial 1.5x - 0.5x^3, only used inside (-ONE, ONE)
    y_cubic = x1_ext + (x1_ext >>> 1) - (x3 >>> 1);
    y_sat   = sat_to($signed({{(32-W3){y_cubic[W3-1]}}, y_cubic}), WIDTH);
`endif
    y_d = y_q;
    if (act2_en) begin
      case (mode)
        MODE_RELU: y_d = x1_q[WIDTH-1] ? '0 : x1_q;
`ifdef NEURON_CUBIC_ACT_EN
        MODE_CUBIC: begin
          if (x1_q >= ONE)       y_d = WIDTH'(ONE);
          else if (x1_q <= -ONE) y_d = WIDTH'(-ONE);
          else                   y_d = WIDTH'(y_sat);
        end
`endif
        default: y_d = x1_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x1_q <= '0;
      y_q  <= '0;
`ifdef NEURON_CUBIC_ACT_EN
      x2_q <= '0;
`endif
    end else begin
      x1_q <= x1_d;
      y_q  <= y_d;
`ifdef NEURON_CUBIC_ACT_EN
      x2_q <= x2_d;
`endif
    end
  end

  assign y = y_q;

endmodule

// File: rtl/serial_neuron_pipe.sv
// rtl/serial_neuron_pipe.sv - word-serial MAC neuron; cubic activation under NEURON_CUBIC_ACT_EN
module serial_neuron_pipe
  import neuron_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int FRAC  = 6,
  parameter int N_MAX = 16,
  parameter int CNT_W = $clog2(N_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_n,
  input  logic [1:0]       cfg_mode,
  input  logic [WIDTH-1:0] bias,
  output logic             busy,
  serial_neuron_pipe_if.slave io
);

  localparam int ACC_W = 2 * WIDTH + $clog2(N_MAX);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        n_q, n_d;
  mode_e                   mode_q, mode_d;
  logic signed [WIDTH-1:0] bias_q, bias_d;
  logic signed [WIDTH-1:0] x_q, x_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    ovf_q, ovf_d;
  logic                    hold_q, hold_d;
  logic                    busy_q, busy_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;

  logic signed [2*WIDTH-1:0] x_ext, w_ext, prod;
  logic signed [ACC_W-1:0]   acc_sh;
  logic signed [ACC_W:0]     s_wide;
  logic signed [31:0]        s_32, s_sat;
  logic [CNT_W-1:0]          n_clamp;
  logic signed [WIDTH-1:0]   y_act;

  assign x_ext   = {{WIDTH{io.in_x[WIDTH-1]}}, io.in_x};
  assign w_ext   = {{WIDTH{io.in_w[WIDTH-1]}}, io.in_w};
  assign prod    = x_ext * w_ext;
  assign acc_sh  = acc_q >>> FRAC;
  assign s_wide  = $signed({acc_sh[ACC_W-1], acc_sh})
                 + $signed({{(ACC_W+1-WIDTH){bias_q[WIDTH-1]}}, bias_q});
  assign s_32    = $signed({{(31-ACC_W){s_wide[ACC_W]}}, s_wide});
  assign s_sat   = sat_to(s_32, WIDTH);
  assign n_clamp = (cfg_n > CNT_W'(N_MAX)) ? CNT_W'(N_MAX) : cfg_n;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    mode_d  = mode_q;
    bias_d  = bias_q;
    x_d     = x_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d   = '0;
          cnt_d   = '0;
          n_d     = n_clamp;
          mode_d  = mode_e'(cfg_mode);
          bias_d  = bias;
          // An empty neuron idles one extra SCALE cycle: fixed four-edge start-to-valid
          hold_d  = (n_clamp == '0);
          state_d = (n_clamp == '0) ? ST_SCALE : ST_ACC;
        end
      end
      ST_ACC: begin
        if (io.in_valid && in_ready_q) begin
          acc_d = acc_q + {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q + CNT_W'(1) == n_q) state_d = ST_SCALE;
        end
      end
      ST_SCALE: begin
        if (hold_q) begin
          hold_d = 1'b0;
        end else begin
          x_d     = WIDTH'(s_sat);
          ovf_d   = (s_sat != s_32);
          state_d = ST_ACT1;
        end
      end
      ST_ACT1: state_d = ST_ACT2;
      ST_ACT2: state_d = ST_OUT;
      ST_OUT:  if (io.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d      = (state_d != ST_IDLE);
    in_ready_d  = (state_d == ST_ACC);
    out_valid_d = (state_d == ST_OUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      n_q         <= '0;
      mode_q      <= MODE_LIN;
      bias_q      <= '0;
      x_q         <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      hold_q      <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      mode_q      <= mode_d;
      bias_q      <= bias_d;
      x_q         <= x_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      hold_q      <= hold_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  neuron_act #(.WIDTH(WIDTH), .FRAC(FRAC)) u_act (
    .clk     (clk),
    .rst_n   (rst_n),
    .act1_en (state_q == ST_ACT1),
    .act2_en (state_q == ST_ACT2),
    .x       (x_q),
    .mode    (mode_q),
    .y       (y_act)
  );

  assign busy         = busy_q;
  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.out_y     = y_act;
  assign io.out_ovf   = ovf_q;

endmodule

// File: doc/serial_neuron_pipe.md
# serial_neuron_pipe

Parametrised successor to the fixed bit-serial neuron core. It computes one neuron output y = act(Σ x_i·w_i + bias) in signed fixed point. Inputs arrive as a word-serial stream, one x/w pair per handshake, with the input count set at run time. Activation is selectable at run time, and both the input stream and the output use valid/ready handshakes. It sits between the layer sequencer (weight/input streamer) and the layer output buffer.

## Interface
- WIDTH, 8, bit width of x, w, bias and y (signed two's complement).
- FRAC, 6, fractional bits. ONE = 1<<FRAC.
- N_MAX, 16, maximum inputs per neuron.
- CNT_W, $clog2(N_MAX+1), width of the count.
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous assert, active-low.
- start  in  1  begin a neuron; accepted only in IDLE.
- cfg_n  in  CNT_W  input count; sampled on start; values above N_MAX clamp to N_MAX.
- cfg_mode  in  2  activation, sampled on start: 00 linear-sat, 01 cubic-sat, 10 relu, 11 treated as 00.
- bias  in  WIDTH  sampled on start.
- busy  out  1  high in any state other than IDLE.
- in_valid / in_ready  in / out  1  input handshake. in_ready = (state==ACC).
- in_x, in_w  in  WIDTH each  operand pair.
- out_valid / out_ready  out / in  1  output handshake.
- out_y  out  WIDTH  result.
- out_ovf  out  1  scaled sum saturated.

## Operation
- States: IDLE → ACC → SCALE → ACT1 → ACT2 → OUT → IDLE.
- IDLE:
  - On start: clear the accumulator and the beat counter; latch cfg_n, cfg_mode and bias.
  - Go to ACC, or go directly to SCALE when the latched n is 0.
- ACC:
  - Each handshake adds x·w (full 2·WIDTH product) into a signed accumulator.
  - Accumulator width is 2·WIDTH + $clog2(N_MAX) and cannot overflow.
  - After the n-th beat, go to SCALE.
- SCALE:
  - s = (acc >>> FRAC) + bias, computed at full width. Arithmetic shift, truncation toward −∞.
  - Saturate s to [−2^(WIDTH−1), 2^(WIDTH−1)−1]. out_ovf = 1 if clipped.
  - Register the result as x.
- ACT1:
  - Compute x2 = (x·x) >>> FRAC.
  - All modes spend this cycle, so latency is fixed.
- ACT2, by mode:
  - linear-sat: y = x.
  - relu: y = (x<0) ? 0 : x.
  - cubic-sat: if x ≥ ONE, y = ONE; if x ≤ −ONE, y = −ONE. Otherwise x3 = (x2·x) >>> FRAC and y = x + (x>>>1) − (x3>>>1).
- OUT:
  - out_valid = 1. out_y and out_ovf are held stable while out_ready = 0.
  - On handshake, go to IDLE.
- Ignored inputs: start outside IDLE, including in the OUT handshake cycle, and in_valid outside ACC.
- Reset: asserting rst at any time, including mid-ACC, clears everything immediately. No partial result is emitted.
- Reset values: busy 0, in_ready 0, out_valid 0, out_y 0, out_ovf 0; state IDLE.

## Timing
- Counting from the edge that accepts the last input beat (edge k): SCALE registers x at k+1, ACT1 at k+2, ACT2 at k+3. out_valid is high from k+3.
- n = 0: start accepted at edge s gives out_valid high from edge s+4.
- Maximum throughput is one input beat per cycle. Per neuron, overhead is start + 3 + ≥1 output cycles.

## Configuration
- NEURON_CUBIC_ACT_EN defined: cubic-sat mode is built, using the x2/x3 multiplier path.
- Undefined: cubic logic is removed and mode 01 behaves exactly as linear-sat. Latency is unchanged (ACT1 and ACT2 still spent).

## Structure
- Package neuron_pkg:
  - mode encoding enum.
  - FSM state enum.
  - saturate-to-WIDTH function.
  - ONE constant helper.
- Sub-module neuron_act: the ACT1/ACT2 activation datapath, combinational plus two register stages. It takes x and mode and produces y.
- The FSM, accumulator and handshakes stay in the top.

## Test plan
Parameters for all scenarios: WIDTH=8, FRAC=6.
- linear, n=2, pairs (32,64),(32,64), bias 0 → y=64, ovf=0, out_valid at k+3.
- cubic, n=1, (32,64), bias 0 → x=32, x2=16, x3=8, y=44. Without the macro → y=32.
- linear, n=4, all pairs (127,127) → y=127, ovf=1. Same in cubic → y=64, ovf=1.
- relu, n=1, (−32,64) → y=0. Linear, n=0, bias −10 → y=0xF6, out_valid at s+4.
- Back-pressure: out_ready held low 5 cycles → out_y stable and start ignored. Gapped in_valid (1 beat every 3 cycles) → same result as the gapless run.
- rst asserted after 2 of 4 beats → in_ready=0 and out_valid=0 at once. A new start then runs cleanly with no residue in the accumulator.
